// File: rtl/mem_access_unit_if.sv
// Wishbone-classic bus bundle between the load/store unit (master) and memory (slave).
interface mem_access_unit_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, we, adr, dat_o, sel,
    input  dat_i, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_o, sel,
    output dat_i, ack, err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store stage: one Wishbone-classic cycle per access, stalls the core until done.
// Optional macro MISALIGN_CHECK_EN rejects misaligned H/W accesses without a bus cycle.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_data,
  input  logic              store_data,
  input  logic [2:0]        funct3,
  input  logic [31:0]       address,
  input  logic [31:0]       store_value,
  output logic              stop_cycle,
  output logic [31:0]       load_result,
  output logic              bus_error,
  mem_access_unit_if.master wb
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 2);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             req;
  logic [3:0]       req_sel;
  logic [31:0]      req_dat;
  logic             bad_align;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] count;
  logic             timeout_hit;
  logic [7:0]       lane_byte;
  logic [15:0]      lane_half;
  logic [31:0]      load_ext;

  assign req = load_data | store_data;

  // Lane enables and replicated write data for the incoming request.
  always_comb begin
    req_sel = 4'b1111;
    req_dat = store_value;
    case (funct3)
      3'b000, 3'b100: begin
        req_sel = 4'b0001 << address[1:0];
        req_dat = {4{store_value[7:0]}};
      end
      3'b001, 3'b101: begin
        req_sel = address[1] ? 4'b1100 : 4'b0011;
        req_dat = {2{store_value[15:0]}};
      end
      default: begin
        req_sel = 4'b1111;
        req_dat = store_value;
      end
    endcase
  end

`ifdef MISALIGN_CHECK_EN
  always_comb begin
    case (funct3)
      3'b000, 3'b100: bad_align = 1'b0;
      3'b001, 3'b101: bad_align = address[0];
      default:        bad_align = |address[1:0];
    endcase
  end
`else
  assign bad_align = 1'b0;
`endif

  always_comb begin
    timeout_hit = (TIMEOUT_CYCLES != 0) && (count == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Extract the addressed lane from the returned word and extend it.
  always_comb begin
    case (off_q)
      2'd0:    lane_byte = wb.dat_i[7:0];
      2'd1:    lane_byte = wb.dat_i[15:8];
      2'd2:    lane_byte = wb.dat_i[23:16];
      default: lane_byte = wb.dat_i[31:24];
    endcase
    lane_half = off_q[1] ? wb.dat_i[31:16] : wb.dat_i[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_ext = {24'b0, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_ext = {16'b0, lane_half};
      default: load_ext = wb.dat_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    stop_cycle = 1'b0;
    case (state)
      IDLE: begin
        stop_cycle = req;
        if (req) state_nxt = bad_align ? DONE : REQ;
      end
      REQ: begin
        stop_cycle = 1'b1;
        if (wb.ack || wb.err || timeout_hit) state_nxt = DONE;
      end
      DONE: begin
        stop_cycle = 1'b0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, bus strobes and result capture; err beats ack, ack beats timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb.cyc      <= 1'b0;
      wb.stb      <= 1'b0;
      wb.we       <= 1'b0;
      wb.adr      <= '0;
      wb.dat_o    <= '0;
      wb.sel      <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      count       <= '0;
      load_result <= '0;
      bus_error   <= 1'b0;
    end else begin
      bus_error <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            wb.we    <= store_data & ~load_data;
            wb.adr   <= {address[31:2], 2'b00};
            wb.sel   <= req_sel;
            wb.dat_o <= req_dat;
            f3_q     <= funct3;
            off_q    <= address[1:0];
            count    <= '0;
            if (bad_align) begin
              bus_error   <= 1'b1;
              load_result <= '0;
            end else begin
              wb.cyc <= 1'b1;
              wb.stb <= 1'b1;
            end
          end
        end
        REQ: begin
          count <= count + 1'b1;
          if (wb.err) begin
            wb.cyc      <= 1'b0;
            wb.stb      <= 1'b0;
            bus_error   <= 1'b1;
            load_result <= '0;
          end else if (wb.ack) begin
            wb.cyc      <= 1'b0;
            wb.stb      <= 1'b0;
            load_result <= wb.we ? 32'h0 : load_ext;
          end else if (timeout_hit) begin
            wb.cyc      <= 1'b0;
            wb.stb      <= 1'b0;
            bus_error   <= 1'b1;
            load_result <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus scoreboard, with a
// hand-written reset-during-access sequence. Built with TIMEOUT_CYCLES = 4.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        load_data;
  logic        store_data;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] store_value;
  logic        stop_cycle;
  logic [31:0] load_result;
  logic        bus_error;

  int checks;
  int failures;

  mem_access_unit_if wb ();

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_data   (load_data),
    .store_data  (store_data),
    .funct3      (funct3),
    .address     (address),
    .store_value (store_value),
    .stop_cycle  (stop_cycle),
    .load_result (load_result),
    .bus_error   (bus_error),
    .wb          (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] val;
    logic [31:0] rdata;
    int          waits;
    logic        use_err;
    logic        hold;
    logic [31:0] e_adr;
    logic [3:0]  e_sel;
    logic        e_we;
    logic [31:0] e_dat;
    logic        chk_dat;
    logic        chk_res;
    logic [31:0] e_res;
    logic        e_berr;
    logic        e_cyc;
    int          e_stall;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];

  function automatic vec_t mk(string n, logic ld, logic st, logic [2:0] f3,
                              logic [31:0] a, logic [31:0] v, logic [31:0] rd,
                              int w, logic er, logic hold,
                              logic [31:0] e_adr, logic [3:0] e_sel, logic e_we,
                              logic [31:0] e_dat, logic chk_dat, logic chk_res,
                              logic [31:0] e_res, logic e_berr, logic e_cyc, int e_stall);
    vec_t r;
    r.name = n; r.ld = ld; r.st = st; r.f3 = f3; r.addr = a; r.val = v; r.rdata = rd;
    r.waits = w; r.use_err = er; r.hold = hold; r.e_adr = e_adr; r.e_sel = e_sel;
    r.e_we = e_we; r.e_dat = e_dat; r.chk_dat = chk_dat; r.chk_res = chk_res;
    r.e_res = e_res; r.e_berr = e_berr; r.e_cyc = e_cyc; r.e_stall = e_stall;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    load_data   = v.ld;
    store_data  = v.st;
    funct3      = v.f3;
    address     = v.addr;
    store_value = v.val;
    sb_q.push_back(v);
    #1;
    check({v.name, ":stop_idle"}, {31'b0, stop_cycle}, 32'd1);
  endtask

  task automatic checkOutput();
    vec_t cur;
    vec_t e;
    int   stall;
    int   req_idx;
    bit   done;
    bit   saw_cyc;
    cur     = sb_q[0];
    stall   = 1;
    req_idx = 0;
    done    = 0;
    saw_cyc = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      wb.ack = 1'b0;
      wb.err = 1'b0;
      if (!cur.hold) begin
        load_data   = 1'b0;
        store_data  = 1'b0;
        funct3      = 3'b000;
        address     = 32'hFFFF_FFFF;
        store_value = $urandom;
      end
      #1;
      if (!stop_cycle) begin
        done = 1;
      end else begin
        stall++;
        if (wb.cyc) begin
          saw_cyc = 1;
          check({cur.name, ":stb"}, {31'b0, wb.stb}, 32'd1);
          check({cur.name, ":adr"}, wb.adr, cur.e_adr);
          check({cur.name, ":sel"}, {28'b0, wb.sel}, {28'b0, cur.e_sel});
          check({cur.name, ":we"}, {31'b0, wb.we}, {31'b0, cur.e_we});
          if (cur.chk_dat) check({cur.name, ":dat_o"}, wb.dat_o, cur.e_dat);
          if (cur.waits >= 0 && req_idx == cur.waits) begin
            wb.dat_i = cur.rdata;
            wb.ack   = 1'b1;
            wb.err   = cur.use_err;
          end
          req_idx++;
        end
      end
    end
    e = sb_q.pop_front();
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s:done_wait actual=stalled expected=done within 40 cycles", e.name);
    end else begin
      check({e.name, ":stall"}, stall, e.e_stall);
      check({e.name, ":bus_error"}, {31'b0, bus_error}, {31'b0, e.e_berr});
      check({e.name, ":cyc_seen"}, {31'b0, saw_cyc}, {31'b0, e.e_cyc});
      check({e.name, ":cyc_done"}, {31'b0, wb.cyc}, 32'd0);
      if (e.chk_res) check({e.name, ":load_result"}, load_result, e.e_res);
    end
    @(negedge clk);
    wb.ack = 1'b0;
    wb.err = 1'b0;
    #1;
    check({e.name, ":berr_pulse"}, {31'b0, bus_error}, 32'd0);
    check({e.name, ":cyc_idle"}, {31'b0, wb.cyc}, 32'd0);
    check({e.name, ":stop_after"}, {31'b0, stop_cycle}, {31'b0, e.hold});
    load_data  = 1'b0;
    store_data = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    load_data   = 1'b0;
    store_data  = 1'b0;
    funct3      = 3'b000;
    address     = '0;
    store_value = '0;
    wb.ack      = 1'b0;
    wb.err      = 1'b0;
    wb.dat_i    = '0;

    repeat (3) @(negedge clk);
    check("rst:cyc", {31'b0, wb.cyc}, 32'd0);
    check("rst:stb", {31'b0, wb.stb}, 32'd0);
    check("rst:we", {31'b0, wb.we}, 32'd0);
    check("rst:adr", wb.adr, 32'd0);
    check("rst:dat_o", wb.dat_o, 32'd0);
    check("rst:sel", {28'b0, wb.sel}, 32'd0);
    check("rst:load_result", load_result, 32'd0);
    check("rst:bus_error", {31'b0, bus_error}, 32'd0);
    check("rst:stop", {31'b0, stop_cycle}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    vecs.push_back(mk("lw_aligned", 1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0,
                      32'h100, 4'hF, 0, 0, 0, 1, 32'hDEADBEEF, 0, 1, 2));
    vecs.push_back(mk("lb_neg", 1, 0, 3'b000, 32'h203, 0, 32'h80112233, 0, 0, 0,
                      32'h200, 4'h8, 0, 0, 0, 1, 32'hFFFFFF80, 0, 1, 2));
    vecs.push_back(mk("lbu", 1, 0, 3'b100, 32'h203, 0, 32'h80112233, 0, 0, 0,
                      32'h200, 4'h8, 0, 0, 0, 1, 32'h00000080, 0, 1, 2));
    vecs.push_back(mk("sh", 0, 1, 3'b001, 32'h302, 32'h0000ABCD, 0, 0, 0, 0,
                      32'h300, 4'hC, 1, 32'hABCDABCD, 1, 0, 0, 0, 1, 2));
    vecs.push_back(mk("lh_wait2", 1, 0, 3'b001, 32'h402, 0, 32'h80017FFF, 2, 0, 0,
                      32'h400, 4'hC, 0, 0, 0, 1, 32'hFFFF8001, 0, 1, 4));
    vecs.push_back(mk("lhu", 1, 0, 3'b101, 32'h400, 0, 32'h12349ABC, 0, 0, 0,
                      32'h400, 4'h3, 0, 0, 0, 1, 32'h00009ABC, 0, 1, 2));
    vecs.push_back(mk("sb", 0, 1, 3'b000, 32'h501, 32'h123456A5, 0, 0, 0, 0,
                      32'h500, 4'h2, 1, 32'hA5A5A5A5, 1, 0, 0, 0, 1, 2));
    vecs.push_back(mk("sw", 0, 1, 3'b010, 32'h600, 32'hCAFEF00D, 0, 1, 0, 0,
                      32'h600, 4'hF, 1, 32'hCAFEF00D, 1, 0, 0, 0, 1, 3));
    vecs.push_back(mk("lb_pos", 1, 0, 3'b000, 32'h701, 0, 32'h00007F00, 0, 0, 0,
                      32'h700, 4'h2, 0, 0, 0, 1, 32'h0000007F, 0, 1, 2));
    vecs.push_back(mk("ld_f3_011", 1, 0, 3'b011, 32'h800, 0, 32'h11223344, 0, 0, 0,
                      32'h800, 4'hF, 0, 0, 0, 1, 32'h11223344, 0, 1, 2));
    vecs.push_back(mk("st_f3_110", 0, 1, 3'b110, 32'h900, 32'h0BADCAFE, 0, 0, 0, 0,
                      32'h900, 4'hF, 1, 32'h0BADCAFE, 1, 0, 0, 0, 1, 2));
    vecs.push_back(mk("err_with_ack", 1, 0, 3'b010, 32'hA00, 0, 32'h99999999, 1, 1, 0,
                      32'hA00, 4'hF, 0, 0, 0, 1, 32'h0, 1, 1, 3));
    vecs.push_back(mk("timeout", 1, 0, 3'b010, 32'hB00, 0, 32'h77777777, -1, 0, 0,
                      32'hB00, 4'hF, 0, 0, 0, 1, 32'h0, 1, 1, 5));
    vecs.push_back(mk("load_priority", 1, 1, 3'b010, 32'hC00, 32'h55555555, 32'h66666666, 0, 0, 0,
                      32'hC00, 4'hF, 0, 0, 0, 1, 32'h66666666, 0, 1, 2));
    vecs.push_back(mk("hold_request", 1, 0, 3'b010, 32'hE00, 0, 32'h0F0F0F0F, 0, 0, 1,
                      32'hE00, 4'hF, 0, 0, 0, 1, 32'h0F0F0F0F, 0, 1, 2));
`ifdef MISALIGN_CHECK_EN
    vecs.push_back(mk("lw_misaligned", 1, 0, 3'b010, 32'h101, 0, 32'h13579BDF, 0, 0, 0,
                      32'h100, 4'hF, 0, 0, 0, 1, 32'h0, 1, 0, 1));
    vecs.push_back(mk("lh_misaligned", 1, 0, 3'b001, 32'h301, 0, 32'hAAAA8765, 0, 0, 0,
                      32'h300, 4'h3, 0, 0, 0, 1, 32'h0, 1, 0, 1));
`else
    vecs.push_back(mk("lw_misaligned", 1, 0, 3'b010, 32'h101, 0, 32'h13579BDF, 0, 0, 0,
                      32'h100, 4'hF, 0, 0, 0, 1, 32'h13579BDF, 0, 1, 2));
    vecs.push_back(mk("lh_misaligned", 1, 0, 3'b001, 32'h301, 0, 32'hAAAA8765, 0, 0, 0,
                      32'h300, 4'h3, 0, 0, 0, 1, 32'hFFFF8765, 0, 1, 2));
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    // Reset in the second REQ cycle, then a stray ack that must be ignored.
    load_data  = 1'b1;
    funct3     = 3'b010;
    address    = 32'hD00;
    @(negedge clk);
    load_data  = 1'b0;
    #1;
    check("rst_mid:cyc_req1", {31'b0, wb.cyc}, 32'd1);
    @(negedge clk);
    #1;
    check("rst_mid:cyc_req2", {31'b0, wb.cyc}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid:cyc_drop", {31'b0, wb.cyc}, 32'd0);
    check("rst_mid:stb_drop", {31'b0, wb.stb}, 32'd0);
    check("rst_mid:stop", {31'b0, stop_cycle}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    wb.dat_i = 32'hFFFF_FFFF;
    wb.ack   = 1'b1;
    @(negedge clk);
    wb.ack = 1'b0;
    #1;
    check("late_ack:cyc", {31'b0, wb.cyc}, 32'd0);
    check("late_ack:stop", {31'b0, stop_cycle}, 32'd0);
    check("late_ack:load_result", load_result, 32'd0);
    check("late_ack:bus_error", {31'b0, bus_error}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
